pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register, the generalised successor to the fixed-field decode/execute register. It carries a control bundle and a data bundle between any two pipeline stages using a valid/ready handshake. A 2-entry skid buffer gives full throughput under back-pressure. Flush inserts a bubble by zeroing control while data is retained.

---
 rtl/pipe_stage_reg.sv | 173 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Parametrised inter-stage pipeline register with a valid/ready handshake.
//   It holds two entries: a main register that drives the outputs and a skid
//   register. The skid entry absorbs the one extra beat that is accepted
//   while downstream back-pressure is still being seen, so the stage keeps
//   full throughput. A flush inserts a bubble by clearing the control bundle
//   of both entries and emptying the stage. The data bundle is either kept
//   or zeroed, depending on CLEAR_DATA_ON_FLUSH.
//
// Parameters
//   CTRL_W              width of the control bundle (zeroed on flush/bubble)
//   DATA_W              width of the data bundle
//   CLEAR_DATA_ON_FLUSH 1 = also zero the data bundle on flush, 0 = keep it
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      kills all held and incoming beats this cycle
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat (depends on state and rst_n only)
//   in_ctrl    upstream control bundle
//   in_data    upstream data bundle
//   out_valid  beat presented downstream
//   out_ready  downstream accepts this cycle
//   out_ctrl   control bundle, all-zero whenever out_valid=0
//   out_data   data bundle (last held value, or zero after reset/clearing flush)
//
// Optional build macro
//   PIPE_STAGE_REG_STATS_EN  adds the saturating counters bubble_cnt and
//                            stall_cnt (32 bits each)
module pipe_stage_reg #(
    parameter int CTRL_W              = 32,
    parameter int DATA_W              = 256,
    parameter int CLEAR_DATA_ON_FLUSH = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_REG_STATS_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [CTRL_W-1:0]   main_ctrl_reg, main_ctrl_next;
    logic [DATA_W-1:0]   main_data_reg, main_data_next;
    logic [CTRL_W-1:0]   skid_ctrl_reg, skid_ctrl_next;
    logic [DATA_W-1:0]   skid_data_reg, skid_data_next;

    logic in_fire;
    logic out_fire;

    // in_ready never looks at out_ready, so no combinational path runs
    // from downstream back to upstream.
    assign in_ready  = rst_n & (state_reg != FULL);
    assign out_valid = (state_reg == ONE) | (state_reg == FULL);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_ctrl  = out_valid ? main_ctrl_reg : '0;
    assign out_data  = main_data_reg;

    always_comb begin
        state_next     = state_reg;
        main_ctrl_next = main_ctrl_reg;
        main_data_next = main_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;

        if (flush) begin
            // Incoming beats are ignored. Any out_fire in this cycle has
            // already been seen by downstream, so the stage drops its copy.
            state_next     = EMPTY;
            main_ctrl_next = '0;
            skid_ctrl_next = '0;
            if (CLEAR_DATA_ON_FLUSH != 0) begin
                main_data_next = '0;
                skid_data_next = '0;
            end
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        state_next     = ONE;
                        main_ctrl_next = in_ctrl;
                        main_data_next = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_next = in_ctrl;
                        main_data_next = in_data;
                    end else if (in_fire) begin
                        state_next     = FULL;
                        skid_ctrl_next = in_ctrl;
                        skid_data_next = in_data;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    // The older beat leaves and the skid entry moves up.
                    if (out_fire) begin
                        state_next     = ONE;
                        main_ctrl_next = skid_ctrl_reg;
                        main_data_next = skid_data_reg;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            main_ctrl_reg <= '0;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_ctrl_reg <= main_ctrl_next;
            main_data_reg <= main_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            skid_data_reg <= skid_data_next;
        end
    end

`ifdef PIPE_STAGE_REG_STATS_EN
    logic [31:0] bubble_cnt_reg;
    logic [31:0] stall_cnt_reg;
    logic        bubble_hit;
    logic        stall_hit;

    // A flush counts as a bubble only if it actually drops something: a held
    // entry or a beat that is being offered.
    assign bubble_hit = flush & ((state_reg != EMPTY) | in_valid);
    assign stall_hit  = out_valid & ~out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_reg <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            if (bubble_hit && (bubble_cnt_reg != 32'hFFFF_FFFF))
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
            if (stall_hit && (stall_cnt_reg != 32'hFFFF_FFFF))
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_reg;
    assign stall_cnt  = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. Two instances share all inputs: dut0
// keeps data on flush and dut1 clears it. Inputs are driven at the falling
// edge. Outputs are checked at the next falling edge, after one rising edge,
// against the hand-computed values in each vector.
module tb_pipe_stage_reg;

    localparam int CW = 32;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [CW-1:0] out_ctrl0, out_ctrl1;
    logic [DW-1:0] out_data0, out_data1;
`ifdef PIPE_STAGE_REG_STATS_EN
    logic [31:0]   bubble_cnt0, stall_cnt0, bubble_cnt1, stall_cnt1;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_ctrl(out_ctrl0), .out_data(out_data0)
`ifdef PIPE_STAGE_REG_STATS_EN
        , .bubble_cnt(bubble_cnt0), .stall_cnt(stall_cnt0)
`endif
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_ctrl(out_ctrl1), .out_data(out_data1)
`ifdef PIPE_STAGE_REG_STATS_EN
        , .bubble_cnt(bubble_cnt1), .stall_cnt(stall_cnt1)
`endif
    );

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        in_valid;
        logic        out_ready;
        logic [7:0]  ctrl;
        logic [15:0] data;
        logic        e_ov;
        logic        e_ir;
        logic [7:0]  e_ctrl;
        logic [15:0] e_d0;
        logic [15:0] e_d1;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic addv(input logic r, input logic f, input logic iv, input logic ordy,
                        input logic [7:0] c, input logic [15:0] d,
                        input logic eov, input logic eir, input logic [7:0] ec,
                        input logic [15:0] ed0, input logic [15:0] ed1);
        vec_t v;
        v.rst_n = r; v.flush = f; v.in_valid = iv; v.out_ready = ordy;
        v.ctrl = c; v.data = d;
        v.e_ov = eov; v.e_ir = eir; v.e_ctrl = ec; v.e_d0 = ed0; v.e_d1 = ed1;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Apply one cycle of inputs and return at the following falling edge.
    task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                         input logic [7:0] c, input logic [15:0] d);
        rst_n     = r;
        flush     = f;
        in_valid  = iv;
        out_ready = ordy;
        in_ctrl   = CW'(c);
        in_data   = DW'(d);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ctrl = '0; in_data = '0;

        // rst  fl  iv  ordy ctrl    data      | ov ir  ctrl   d0       d1
        addv(0, 0, 0, 1, 8'h00, 16'h0000,   0, 0, 8'h00, 16'h0000, 16'h0000);
        addv(0, 0, 0, 1, 8'h00, 16'h0000,   0, 0, 8'h00, 16'h0000, 16'h0000);
        // Stream 1..8 at full rate.
        for (int k = 1; k <= 8; k++)
            addv(1, 0, 1, 1, 8'(k), 16'(16'h100 + k), 1, 1, 8'(k), 16'(16'h100 + k), 16'(16'h100 + k));
        addv(1, 0, 0, 1, 8'h00, 16'h0000,   0, 1, 8'h00, 16'h0108, 16'h0108);
        // Back-pressure: fill to FULL, hold, then drain in order.
        addv(1, 0, 1, 0, 8'h11, 16'h0211,   1, 1, 8'h11, 16'h0211, 16'h0211);
        addv(1, 0, 1, 0, 8'h22, 16'h0222,   1, 0, 8'h11, 16'h0211, 16'h0211);
        addv(1, 0, 1, 0, 8'h33, 16'h0233,   1, 0, 8'h11, 16'h0211, 16'h0211);
        addv(1, 0, 1, 1, 8'h33, 16'h0233,   1, 1, 8'h22, 16'h0222, 16'h0222);
        addv(1, 0, 1, 1, 8'h33, 16'h0233,   1, 1, 8'h33, 16'h0233, 16'h0233);
        addv(1, 0, 0, 1, 8'h00, 16'h0000,   0, 1, 8'h00, 16'h0233, 16'h0233);
        // Flush while FULL with a beat offered (0x44 must never appear).
        addv(1, 0, 1, 0, 8'h55, 16'h0355,   1, 1, 8'h55, 16'h0355, 16'h0355);
        addv(1, 0, 1, 0, 8'h66, 16'h0366,   1, 0, 8'h55, 16'h0355, 16'h0355);
        addv(1, 1, 1, 0, 8'h44, 16'h00AB,   0, 1, 8'h00, 16'h0355, 16'h0000);
        addv(1, 0, 0, 1, 8'h00, 16'h0000,   0, 1, 8'h00, 16'h0355, 16'h0000);
        // Flush while ONE together with an out_fire, then a second flush cycle.
        addv(1, 0, 1, 1, 8'h77, 16'h0377,   1, 1, 8'h77, 16'h0377, 16'h0377);
        addv(1, 1, 0, 1, 8'h00, 16'h0000,   0, 1, 8'h00, 16'h0377, 16'h0000);
        addv(1, 1, 1, 1, 8'h78, 16'h0378,   0, 1, 8'h00, 16'h0377, 16'h0000);
        // Reset together with flush while ONE: reset wins.
        addv(1, 0, 1, 0, 8'h99, 16'h0399,   1, 1, 8'h99, 16'h0399, 16'h0399);
        addv(0, 1, 1, 0, 8'h9A, 16'h039A,   0, 0, 8'h00, 16'h0000, 16'h0000);
        addv(1, 0, 0, 1, 8'h00, 16'h0000,   0, 1, 8'h00, 16'h0000, 16'h0000);
        addv(1, 0, 1, 1, 8'hAA, 16'h0AAA,   1, 1, 8'hAA, 16'h0AAA, 16'h0AAA);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready,
                  vecs[i].ctrl, vecs[i].data);
            $display("vec %0d: ov=%0b ir=%0b ctrl=%0h data0=%0h data1=%0h",
                     i, out_valid0, in_ready0, out_ctrl0, out_data0[15:0], out_data1[15:0]);
            chk("out_valid",  i, DW'(out_valid0), DW'(vecs[i].e_ov));
            chk("in_ready",   i, DW'(in_ready0),  DW'(vecs[i].e_ir));
            chk("out_ctrl",   i, DW'(out_ctrl0),  DW'(vecs[i].e_ctrl));
            chk("out_data0",  i, out_data0,       DW'(vecs[i].e_d0));
            chk("out_ctrl1",  i, DW'(out_ctrl1),  DW'(vecs[i].e_ctrl));
            chk("out_data1",  i, out_data1,       DW'(vecs[i].e_d1));
            chk("in_ready1",  i, DW'(in_ready1),  DW'(vecs[i].e_ir));
        end

        // Reset mid-stream while FULL drops both entries.
        drive(1, 0, 1, 0, 8'hBB, 16'h0BBB);
        $display("seq fill: ir=%0b ctrl=%0h", in_ready0, out_ctrl0);
        chk("full_in_ready", 100, DW'(in_ready0), DW'(1'b0));
        chk("full_ctrl",     100, DW'(out_ctrl0), DW'(8'hAA));
        drive(0, 0, 0, 1, 8'h00, 16'h0000);
        $display("seq reset: ov=%0b ir=%0b data=%0h", out_valid0, in_ready0, out_data0[15:0]);
        chk("rst_out_valid", 101, DW'(out_valid0), DW'(1'b0));
        chk("rst_in_ready",  101, DW'(in_ready0),  DW'(1'b0));
        chk("rst_out_data",  101, out_data0,       DW'(0));
`ifdef PIPE_STAGE_REG_STATS_EN
        chk("rst_stall_cnt",  101, DW'(stall_cnt0),  DW'(0));
        chk("rst_bubble_cnt", 101, DW'(bubble_cnt0), DW'(0));
`endif
        // Three stall cycles, then a flush that drops two beats.
        drive(1, 0, 1, 0, 8'h01, 16'h0001);
        drive(1, 0, 1, 0, 8'h02, 16'h0002);
        drive(1, 0, 0, 0, 8'h00, 16'h0000);
        drive(1, 0, 0, 0, 8'h00, 16'h0000);
        $display("seq stall: ov=%0b ir=%0b ctrl=%0h", out_valid0, in_ready0, out_ctrl0);
        chk("stall_ctrl",     102, DW'(out_ctrl0), DW'(8'h01));
        chk("stall_in_ready", 102, DW'(in_ready0), DW'(1'b0));
`ifdef PIPE_STAGE_REG_STATS_EN
        chk("stall_cnt",      102, DW'(stall_cnt0),  DW'(3));
        chk("bubble_pre",     102, DW'(bubble_cnt0), DW'(0));
`endif
        drive(1, 1, 0, 1, 8'h00, 16'h0000);
        $display("seq flush: ov=%0b ir=%0b ctrl=%0h", out_valid0, in_ready0, out_ctrl0);
        chk("flush_out_valid", 103, DW'(out_valid0), DW'(1'b0));
        chk("flush_in_ready",  103, DW'(in_ready0),  DW'(1'b1));
`ifdef PIPE_STAGE_REG_STATS_EN
        chk("bubble_cnt",      103, DW'(bubble_cnt0), DW'(1));
        chk("stall_after",     103, DW'(stall_cnt0),  DW'(3));
`endif
        // A flush while EMPTY drops nothing.
        drive(1, 1, 0, 1, 8'h00, 16'h0000);
        $display("seq empty flush: ov=%0b ctrl=%0h", out_valid0, out_ctrl0);
        chk("eflush_ctrl", 104, DW'(out_ctrl0), DW'(0));
`ifdef PIPE_STAGE_REG_STATS_EN
        chk("bubble_empty", 104, DW'(bubble_cnt0), DW'(1));
        chk("bubble_dut1",  104, DW'(bubble_cnt1), DW'(1));
        chk("stall_dut1",   104, DW'(stall_cnt1),  DW'(3));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
